vmcmp_accum: RTL

- Next-generation vector mask-compare unit for the vALU.
- Performs element-wise integer compares at SEW 8/16/32/64 and packs the result bits contiguously into MASK_WIDTH-bit mask words across multiple beats of one instruction.
- Emits one write per completed mask word, with byte enables and the destination address.
- Adds over the previous generation: two's-complement signed compare, gt ops, per-beat active-element count (tail), multi-beat accumulation, and configurable output delay.

---
 rtl/vmcmp_pkg.sv | 46 ++++
 rtl/vmcmp_lane_cmp.sv | 58 +++++
 rtl/vmcmp_accum.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vmcmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmcmp_pkg
// Description : Shared opcodes, SEW encodings and helpers for the vector
//               mask-compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
package vmcmp_pkg;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LTU = 3'b010;
  localparam logic [2:0] OP_LT  = 3'b011;
  localparam logic [2:0] OP_LEU = 3'b100;
  localparam logic [2:0] OP_LE  = 3'b101;
  localparam logic [2:0] OP_GTU = 3'b110;
  localparam logic [2:0] OP_GT  = 3'b111;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  function automatic int unsigned elems_per_beat(input logic [1:0] sew, input int unsigned width);
    return width >> (3 + int'(sew));
  endfunction

  // The le/gt forms are derived from eq and lt so signedness lives in one place.
  function automatic logic cmp_result(input logic [2:0] op, input logic eq, input logic ltu,
                                      input logic lt);
    logic r;
    case (op)
      OP_EQ:   r = eq;
      OP_NE:   r = ~eq;
      OP_LTU:  r = ltu;
      OP_LT:   r = lt;
      OP_LEU:  r = ltu | eq;
      OP_LE:   r = lt | eq;
      OP_GTU:  r = ~(ltu | eq);
      default: r = ~(lt | eq);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmcmp_lane_cmp.sv
`default_nettype none
// ============================================================================
// Module      : vmcmp_lane_cmp
// Description : Element-wise compare of one operand beat at SEW 8/16/32/64,
//               returning one result bit per lane (inactive lanes forced to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module vmcmp_lane_cmp
  import vmcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]           vec0,
  input  logic [DATA_WIDTH-1:0]           vec1,
  input  logic [1:0]                      sew,
  input  logic [2:0]                      op_sel,
  input  logic [$clog2(DATA_WIDTH/8):0]   elem_cnt,
  output logic [DATA_WIDTH/8-1:0]         res
);

  localparam int c_lanes = DATA_WIDTH / 8;
  localparam int c_cnt_w = $clog2(c_lanes) + 1;

  logic [3:0][c_lanes-1:0] w_res_sew;
  logic [c_lanes-1:0]      w_sel;

  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int c_ew = 8 << s;
    localparam int c_ne = DATA_WIDTH / c_ew;
    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      if (i < c_ne) begin : g_act
        logic [c_ew-1:0] w_a;
        logic [c_ew-1:0] w_b;
        logic            w_eq;
        logic            w_ltu;
        logic            w_lt;
        assign w_a   = vec0[i*c_ew +: c_ew];
        assign w_b   = vec1[i*c_ew +: c_ew];
        assign w_eq  = (w_a == w_b);
        assign w_ltu = (w_a < w_b);
        assign w_lt  = ($signed(w_a) < $signed(w_b));
        assign w_res_sew[s][i] = cmp_result(op_sel, w_eq, w_ltu, w_lt);
      end else begin : g_pad
        assign w_res_sew[s][i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel = w_res_sew[sew];
    res   = '0;
    for (int i = 0; i < c_lanes; i++) begin
      res[i] = w_sel[i] & (c_cnt_w'(i) < elem_cnt);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vmcmp_accum.sv
`default_nettype none
// ============================================================================
// Module      : vmcmp_accum
// Description : Vector mask-compare unit; packs per-lane compare bits across
//               beats into MASK_WIDTH-bit words and emits one write per word.
// Revision    : 1.0 - initial release
// ============================================================================
module vmcmp_accum
  import vmcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int OUT_STAGES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic [DATA_WIDTH-1:0]         in_vec0,
  input  logic [DATA_WIDTH-1:0]         in_vec1,
  input  logic [1:0]                    in_sew,
  input  logic [2:0]                    in_opSel,
  input  logic [$clog2(DATA_WIDTH/8):0] in_elem_cnt,
  output logic                          out_valid,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [MASK_WIDTH-1:0]         out_vec,
  output logic [MASK_WIDTH/8-1:0]       out_be
);

  localparam int c_lanes   = DATA_WIDTH / 8;
  localparam int c_cnt_w   = $clog2(c_lanes) + 1;
  localparam int c_ptr_w   = $clog2(MASK_WIDTH) + 1;
  localparam int c_be_w    = MASK_WIDTH / 8;
  localparam int c_widx_sh = $clog2(c_be_w);

  // Input capture stage
  logic                  r0_valid, r0_first, r0_last;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_vec0, r0_vec1;
  logic [1:0]            r0_sew;
  logic [2:0]            r0_op;
  logic [c_cnt_w-1:0]    r0_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r0_first <= 1'b0;
      r0_last  <= 1'b0;
      r0_addr  <= '0;
      r0_vec0  <= '0;
      r0_vec1  <= '0;
      r0_sew   <= '0;
      r0_op    <= '0;
      r0_cnt   <= '0;
    end else begin
      r0_valid <= in_valid;
      r0_first <= in_valid & in_first;
      r0_last  <= in_valid & in_last;
      r0_addr  <= in_valid ? in_addr     : '0;
      r0_vec0  <= in_valid ? in_vec0     : '0;
      r0_vec1  <= in_valid ? in_vec1     : '0;
      r0_sew   <= in_valid ? in_sew      : '0;
      r0_op    <= in_valid ? in_opSel    : '0;
      r0_cnt   <= in_valid ? in_elem_cnt : '0;
    end
  end

  logic [c_lanes-1:0] w_cmp;

  vmcmp_lane_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_cmp (
    .vec0     (r0_vec0),
    .vec1     (r0_vec1),
    .sew      (r0_sew),
    .op_sel   (r0_op),
    .elem_cnt (r0_cnt),
    .res      (w_cmp)
  );

  // Accumulation state
  logic [MASK_WIDTH-1:0] r_acc;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [ADDR_WIDTH-1:0] r_base;

  logic [MASK_WIDTH-1:0] w_acc_in, w_merged;
  logic [c_ptr_w-1:0]    w_ptr_in, w_ptr_sum, w_ptr_final, w_nbytes;
  logic [ADDR_WIDTH-1:0] w_widx_in, w_base_in, w_addr;
  logic [c_be_w-1:0]     w_be;
  logic                  w_full, w_done;

  // A first beat restarts the instruction before its own bits are merged.
  always_comb begin
    w_acc_in    = r0_first ? '0      : r_acc;
    w_ptr_in    = r0_first ? '0      : r_ptr;
    w_widx_in   = r0_first ? '0      : r_widx;
    w_base_in   = r0_first ? r0_addr : r_base;
    w_merged    = w_acc_in | (MASK_WIDTH'(w_cmp) << w_ptr_in);
    w_ptr_sum   = w_ptr_in + c_ptr_w'(r0_cnt);
    w_full      = (w_ptr_sum >= c_ptr_w'(MASK_WIDTH));
    w_ptr_final = w_full ? c_ptr_w'(MASK_WIDTH) : w_ptr_sum;
    w_done      = r0_valid & (w_full | r0_last);
    w_nbytes    = (w_ptr_final + c_ptr_w'(7)) >> 3;
    w_be        = ~({c_be_w{1'b1}} << w_nbytes);
    w_addr      = w_base_in + (w_widx_in << c_widx_sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_ptr  <= '0;
      r_widx <= '0;
      r_base <= '0;
    end else if (r0_valid) begin
      r_base <= w_base_in;
      if (w_done) begin
        r_acc  <= '0;
        r_ptr  <= '0;
        r_widx <= r0_last ? '0 : (w_widx_in + ADDR_WIDTH'(1));
      end else begin
        r_acc  <= w_merged;
        r_ptr  <= w_ptr_sum;
        r_widx <= w_widx_in;
      end
    end
  end

  // Output register: zero whenever no word is being written
  logic                  r_ovalid;
  logic [ADDR_WIDTH-1:0] r_oaddr;
  logic [MASK_WIDTH-1:0] r_ovec;
  logic [c_be_w-1:0]     r_obe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovalid <= 1'b0;
      r_oaddr  <= '0;
      r_ovec   <= '0;
      r_obe    <= '0;
    end else begin
      r_ovalid <= w_done;
      r_oaddr  <= w_done ? w_addr   : '0;
      r_ovec   <= w_done ? w_merged : '0;
      r_obe    <= w_done ? w_be     : '0;
    end
  end

  if (OUT_STAGES == 0) begin : g_no_pipe
    assign out_valid = r_ovalid;
    assign out_addr  = r_oaddr;
    assign out_vec   = r_ovec;
    assign out_be    = r_obe;
  end else begin : g_pipe
    logic [OUT_STAGES-1:0] r_pv;
    logic [ADDR_WIDTH-1:0] r_pa [OUT_STAGES];
    logic [MASK_WIDTH-1:0] r_pd [OUT_STAGES];
    logic [c_be_w-1:0]     r_pb [OUT_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pv <= '0;
        for (int k = 0; k < OUT_STAGES; k++) begin
          r_pa[k] <= '0;
          r_pd[k] <= '0;
          r_pb[k] <= '0;
        end
      end else begin
        r_pv[0] <= r_ovalid;
        r_pa[0] <= r_oaddr;
        r_pd[0] <= r_ovec;
        r_pb[0] <= r_obe;
        for (int k = 1; k < OUT_STAGES; k++) begin
          r_pv[k] <= r_pv[k-1];
          r_pa[k] <= r_pa[k-1];
          r_pd[k] <= r_pd[k-1];
          r_pb[k] <= r_pb[k-1];
        end
      end
    end

    assign out_valid = r_pv[OUT_STAGES-1];
    assign out_addr  = r_pa[OUT_STAGES-1];
    assign out_vec   = r_pd[OUT_STAGES-1];
    assign out_be    = r_pb[OUT_STAGES-1];
  end

endmodule
`default_nettype wire
